// File: rtl/key_pkg.sv
// ----------------------------------------------------------------------------
// key_pkg
// Shared definitions for the key debouncer: the per-key FSM state encoding,
// the default 50 MHz timing constants, reduced constants for short
// simulations, and a helper that turns a cycle count into the terminal value
// of a counter that starts at zero.
// ----------------------------------------------------------------------------
package key_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        P_WAIT = 2'd1,
        DOWN   = 2'd2,
        R_WAIT = 2'd3
    } key_state_e;

    // Default timing at 50 MHz.
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;   // 20 ms
    localparam int DEF_HOLD_CYCLES     = 25000000;  // 0.5 s
    localparam int DEF_REPEAT_CYCLES   = 5000000;   // 0.1 s
    localparam int DEF_CNT_W           = 25;

    // Reduced timing for simulation.
    localparam int SIM_DEBOUNCE_CYCLES = 8;
    localparam int SIM_HOLD_CYCLES     = 20;
    localparam int SIM_REPEAT_CYCLES   = 5;

    // Terminal count for a counter running 0..cycles-1; never negative.
    function automatic int last_count(input int cycles);
        return (cycles > 32'sd0) ? (cycles - 32'sd1) : 32'sd0;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// ----------------------------------------------------------------------------
// key_debounce_ch
// One debounce channel: 2-flop synchroniser, state machine and shared
// timing counter for a single active-low key.
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   sw_n_i     raw key input, low = pressed, asynchronous to clk
//   press_o    one-cycle pulse when a press is accepted
//   release_o  one-cycle pulse when a release is accepted
//   level_o    high while the debounced key is held
//   repeat_o   one-cycle auto-repeat pulses while held
// ----------------------------------------------------------------------------
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_n_i,
    output logic press_o,
    output logic release_o,
    output logic level_o,
    output logic repeat_o
);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(last_count(DEBOUNCE_CYCLES));
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(last_count(HOLD_CYCLES));
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(last_count(REPEAT_CYCLES));
    localparam bit               REPEAT_EN = (HOLD_CYCLES != 0);

    logic             sync1_q;
    logic             sync2_q;
    key_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rep_phase_q;   // 0: waiting for first repeat, 1: periodic
    logic             press_q;
    logic             release_q;
    logic             level_q;
    logic             repeat_q;

    // Two-flop synchroniser; resets to the released level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= sw_n_i;
            sync2_q <= sync1_q;
        end
    end

    // Debounce FSM with counter and registered outputs. The counter is
    // cleared on every state change and at every terminal count, so it
    // never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rep_phase_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            level_q     <= 1'b0;
            repeat_q    <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    level_q <= 1'b0;
                    cnt_q   <= '0;
                    if (!sync2_q) begin
                        state_q <= P_WAIT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                P_WAIT: begin
                    if (sync2_q) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_q     <= DOWN;
                        cnt_q       <= '0;
                        rep_phase_q <= 1'b0;
                        press_q     <= 1'b1;
                        level_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DOWN: begin
                    level_q <= 1'b1;
                    if (sync2_q) begin
                        state_q <= R_WAIT;
                        cnt_q   <= '0;
                    end else if (!REPEAT_EN) begin
                        cnt_q <= '0;
                    end else if (cnt_q == (rep_phase_q ? REP_LAST : HOLD_LAST)) begin
                        // First terminal is the hold time, later ones the period.
                        repeat_q    <= 1'b1;
                        rep_phase_q <= 1'b1;
                        cnt_q       <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                R_WAIT: begin
                    if (!sync2_q) begin
                        // Bounce during release: back to held, repeat timing restarts.
                        state_q     <= DOWN;
                        cnt_q       <= '0;
                        rep_phase_q <= 1'b0;
                    end else if (cnt_q == DB_LAST) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        release_q <= 1'b1;
                        level_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cnt_q       <= '0;
                    rep_phase_q <= 1'b0;
                    level_q     <= 1'b0;
                end
            endcase
        end
    end

    assign press_o   = press_q;
    assign release_o = release_q;
    assign level_o   = level_q;
    assign repeat_o  = repeat_q;

endmodule

// File: rtl/key_debounce.sv
// ----------------------------------------------------------------------------
// key_debounce
// N independent active-low key debouncers feeding the marquee controller.
// Ports:
//   clk          clock (50 MHz)
//   rst_n        asynchronous active-low reset
//   sw_n         raw key inputs, low = pressed
//   key_press    one-cycle pulse per accepted press
//   key_release  one-cycle pulse per accepted release
//   key_level    high while a debounced key is held
//   key_repeat   one-cycle auto-repeat pulses while held
// ----------------------------------------------------------------------------
module key_debounce
    import key_pkg::*;
#(
    parameter int N_KEYS          = 3,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] sw_n,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_repeat
);

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .sw_n_i    (sw_n[g]),
            .press_o   (key_press[g]),
            .release_o (key_release[g]),
            .level_o   (key_level[g]),
            .repeat_o  (key_repeat[g])
        );
    end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Upstream input stage for the marquee LED controller.
- Takes N raw active-low push-button inputs and synchronises each to clk, then debounces it with a per-key state machine.
- Emits single-cycle press and release pulses plus a stable pressed level. The press pulses replace the marquee's internal edge-detect and 20 ms sampling logic and drive its on/off and left/right controls directly.
- Optional long-press auto-repeat pulses.

Parameters:
- N_KEYS, 3, number of independent keys.
- DEBOUNCE_CYCLES, 1000000, cycles an input must stay stable before a change is accepted (20 ms at 50 MHz).
- HOLD_CYCLES, 25000000, cycles in pressed state before the first repeat pulse (0.5 s).
- REPEAT_CYCLES, 5000000, cycles between subsequent repeat pulses (0.1 s).
- CNT_W, 25, counter width; must hold max(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES).

Ports:
- clk  input  1  main clock, 50 MHz.
- rst_n  input  1  reset, asynchronous, active-low.
- sw_n  input  N_KEYS  raw key inputs, low = pressed, asynchronous to clk.
- key_press  output  N_KEYS  one-cycle pulse per accepted press.
- key_release  output  N_KEYS  one-cycle pulse per accepted release.
- key_level  output  N_KEYS  1 while the debounced key is held.
- key_repeat  output  N_KEYS  one-cycle auto-repeat pulses while held.

Behaviour:
- Clocking and reset: one clock domain, clk. rst_n is asynchronous, active-low; all flops reset asynchronously.
- Reset values:
  - Synchroniser flops: 1 (released).
  - FSM: IDLE.
  - Counters: 0.
  - key_press, key_release, key_level, key_repeat: all 0.
- Reset mid-operation: immediately returns every channel to IDLE with outputs low. No release pulse is issued for a key held across reset.
- Synchroniser: 2-flop synchroniser per key; sync = second stage.
- Channels are fully independent. Simultaneous presses on several keys produce simultaneous pulses; there is no priority.
- Per-key FSM states and transitions:
  - IDLE: if sync==0, go to P_WAIT and clear cnt.
  - P_WAIT:
    - If sync==1, go to IDLE (bounce rejected, no output).
    - Else cnt++.
    - When cnt==DEBOUNCE_CYCLES-1 and sync==0, go to DOWN, clear cnt, pulse key_press.
  - DOWN:
    - key_level=1.
    - If sync==1, go to R_WAIT and clear cnt.
    - Else cnt++ for repeat timing: first key_repeat when cnt reaches HOLD_CYCLES-1, then every REPEAT_CYCLES cycles while held.
  - R_WAIT:
    - key_level stays 1.
    - If sync==0, go to DOWN (bounce rejected; repeat timing restarts from 0).
    - Else cnt++; at DEBOUNCE_CYCLES-1, go to IDLE and pulse key_release.
- Latency: if edge k is the first edge sampling sw_n low and the input stays low, key_press is high for exactly the cycle after edge k+DEBOUNCE_CYCLES+2. Release latency is symmetric. key_level rises the same cycle as key_press and falls the same cycle as key_release.
- Output registration: all outputs are registered; there is no combinational path from sw_n.
- Exclusivity: key_press, key_repeat and key_release are never asserted together on the same key. The counter must not wrap; it saturates or clears at every terminal count.
- Glitch rejection: any glitch shorter than DEBOUNCE_CYCLES-1 cycles produces no pulse.
- Repeat disable: HOLD_CYCLES==0 disables repeat; key_repeat is held at 0.

Decomposition:
- Shared package key_pkg:
  - FSM state typedef (IDLE, P_WAIT, DOWN, R_WAIT; 2-bit).
  - Default timing constants at 50 MHz.
  - Reduced simulation constants: DEBOUNCE 8, HOLD 20, REPEAT 5.
- One sub-module, key_debounce_ch:
  - Contains one synchroniser, FSM and counter.
  - The top instantiates it N_KEYS times in a generate loop.

Test Plan (DEBOUNCE_CYCLES=8, HOLD_CYCLES=20, REPEAT_CYCLES=5, N_KEYS=3):
- Clean press: sw_n[0] falls before edge 10 and stays low -> key_press[0]=1 only in the cycle after edge 20; key_level[0] rises in the same cycle; other keys stay 0.
- Bounce reject: sw_n[1] toggles low/high with 3-cycle segments for 30 cycles, then stays high -> no key_press, key_release or key_level activity on key 1.
- Release: sw_n[0] returns high 50 cycles after the press -> exactly one key_release[0] pulse, 10 cycles after the first high sample; key_level[0] falls in the same cycle.
- Auto-repeat: hold sw_n[2] low for 60 cycles after the accepted press -> key_repeat[2] pulses at 20, 25, 30 … cycles after key_press; none after the release starts.
- Simultaneous keys: sw_n goes 3'b111 to 3'b000 on one edge -> key_press=3'b111 in a single cycle.
- Reset mid-press: assert rst_n low while in DOWN -> all outputs 0 asynchronously. Release rst_n with the key still held -> a new key_press after full debounce latency; no key_release ever issued for the pre-reset press.
